burst_ram_arbiter: RTL and testbench
====================================

# burst_ram_arbiter

Two-requester controller that shares one burst RAM port between an instruction-side and a data-side cache. It accepts whole-line read/write requests, grants them round-robin, sequences the RAM command and burst, and packs/unpacks the line into RAM words. Sits between the two cache controllers and the burst RAM (emulator in simulation, vendor IP on hardware).

## Interface
- DataBitWidth, 64, RAM word width in bits; divisible by 8
- AddressBitWidth, 4, RAM word address width
- BurstDataCount, 4, words per burst; power of two, at least 2
- LineAddrWidth, AddressBitWidth - $clog2(BurstDataCount), derived line address width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- req  in  [2]  request per requester, index 0 = icache, 1 = dcache
- req_we  in  [2]  1: write line, 0: read line
- req_addr  in  [2][LineAddrWidth]  line address
- req_wdata  in  [2][DataBitWidth*BurstDataCount]  write line; word k at bits [k*DataBitWidth +: DataBitWidth]
- ack  out  [2]  one-cycle completion pulse per requester
- rdata  out  DataBitWidth*BurstDataCount  last read line, same packing
- ram_cmd  out  1  0: read, 1: write
- ram_cmd_en  out  1  command valid
- ram_addr  out  AddressBitWidth  {line address, zeros}
- ram_wr_data  out  DataBitWidth  write word
- ram_data_mask  out  DataBitWidth/8  tied 0
- ram_rd_data  in  DataBitWidth  read word
- ram_rd_data_valid  in  1  read word valid
- ram_init_calib  in  1  RAM ready
- ram_busy  in  1  RAM not accepting commands

## Operation
- States: WaitCalib, Idle, WriteBurst, ReadWait, ReadBurst.
- WaitCalib: no commands; leave when ram_init_calib = 1.
- Idle: if !ram_busy and any req, grant. One requesting: grant it. Both: grant the one not granted last (last_grant resets to 1, so icache wins first tie). Latch we, addr, wdata of grantee; assert ram_cmd_en with ram_cmd = we, ram_addr = {addr, 0}; for writes ram_wr_data = word 0 in same cycle.
- WriteBurst: drive words 1..BurstDataCount-1 on consecutive cycles; after last word pulse ack[grant], return to Idle.
- ReadWait: wait for ram_rd_data_valid; ReadBurst: store each valid word into slot word_cnt, increment; after word BurstDataCount-1, pulse ack[grant] with rdata holding the full line, return to Idle.
- ram_rd_data_valid outside ReadWait/ReadBurst ignored; gap in valid during ReadBurst stalls the counter (no word lost).
- Requester must hold req and operands until ack; request contents are latched at grant, so dropping req after grant still completes and acks.
- rdata holds last completed read line until next read completes; not updated by writes.
- word_cnt is $clog2(BurstDataCount) bits, wraps to 0 at end of burst.

## Timing
- Reset (async assert, sync deassert by system): state WaitCalib, ack 0, rdata 0, ram_cmd 0, ram_cmd_en 0, ram_addr 0, ram_wr_data 0, last_grant 1.
- All outputs registered.
- Write: command at cycle T (word 0), words k at T+k, ack at T+BurstDataCount.
- Read: command at T, ack the cycle after the final ram_rd_data_valid word is captured.
- ram_cmd_en high exactly one cycle per grant; never issued while ram_busy = 1 or in WaitCalib.
- Back-to-back: next grant no earlier than the cycle after ack and when ram_busy low.
- Reset mid-burst: abort immediately, no ack; RAM shares rst_n.

## Structure
- Package burst_ram_pkg: state enum, CMD_READ = 0, CMD_WRITE = 1.
- Sub-module rr_arbiter (2-way round-robin: req, update, grant, last_grant register).

## Test plan
- Calibration: ram_init_calib low 10 cycles, req[0] read held -> no ram_cmd_en until calibration, then read issued.
- Single write: req[1] write line 3, words 0x11,0x22,0x33,0x44 -> ram_addr 12, words at T..T+3, ack[1] at T+4; read back matches.
- Single read: req[0] read line 3 with read delay 6 -> rdata = {0x44,0x33,0x22,0x11}, ack[0] once.
- Contention: both req high from reset -> icache first, dcache second; repeat both -> alternation 0,1,0,1.
- Top line wrap: line 3 with AddressBitWidth 4 -> ram_addr 12..15 only, no corruption of line 0.
- Reset mid-ReadBurst after 2 words -> no ack, outputs at reset values, next request completes normally.

Source files
------------

// File: rtl/burst_ram_arbiter_pkg.sv
// Shared definitions for the burst RAM arbiter: controller states and RAM command encodings.
package burst_ram_pkg;

   typedef enum logic [2:0] {
      WaitCalib,
      Idle,
      WriteBurst,
      ReadWait,
      ReadBurst
   } state_t;

   localparam logic CMD_READ  = 1'b0;
   localparam logic CMD_WRITE = 1'b1;

endpackage

// File: rtl/burst_ram_arbiter_rr_arbiter.sv
// Two-way round-robin arbiter: a tie goes to the requester that was not granted last.
module rr_arbiter
   import burst_ram_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] i_req,
   input  logic       i_update,
   output logic       o_grant,
   output logic       o_valid
);

   logic r_lastGrant;

   always_comb begin
      o_valid = |i_req;
      o_grant = 1'b0;
      unique case (i_req)
         2'b10:   o_grant = 1'b1;
         2'b11:   o_grant = ~r_lastGrant;
         default: o_grant = 1'b0;
      endcase
   end

   // Starting at 1 lets the icache win the first tie after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lastGrant <= 1'b1;
      end else if (i_update && o_valid) begin
         r_lastGrant <= o_grant;
      end
   end

endmodule

// File: rtl/burst_ram_arbiter.sv
// Shares one burst RAM port between icache and dcache: grants whole-line requests round-robin
// and sequences the command, write burst words and read word capture.
module burst_ram_arbiter
   import burst_ram_pkg::*;
#(
   parameter int DataBitWidth    = 64,
   parameter int AddressBitWidth = 4,
   parameter int BurstDataCount  = 4,
   parameter int LineAddrWidth   = AddressBitWidth - $clog2(BurstDataCount)
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic [1:0]                             req,
   input  logic [1:0]                             req_we,
   input  logic [LineAddrWidth-1:0]               req_addr [2],
   input  logic [DataBitWidth*BurstDataCount-1:0] req_wdata [2],
   output logic [1:0]                             ack,
   output logic [DataBitWidth*BurstDataCount-1:0] rdata,
   output logic                                   ram_cmd,
   output logic                                   ram_cmd_en,
   output logic [AddressBitWidth-1:0]             ram_addr,
   output logic [DataBitWidth-1:0]                ram_wr_data,
   output logic [DataBitWidth/8-1:0]              ram_data_mask,
   input  logic [DataBitWidth-1:0]                ram_rd_data,
   input  logic                                   ram_rd_data_valid,
   input  logic                                   ram_init_calib,
   input  logic                                   ram_busy
);

   localparam int WordCntWidth = $clog2(BurstDataCount);
   localparam int LineBits     = DataBitWidth * BurstDataCount;
   localparam logic [WordCntWidth-1:0] LastWord = WordCntWidth'(BurstDataCount - 1);

   state_t                       r_state;
   logic                         r_grant;
   logic [LineBits-1:0]          r_wdata;
   logic [WordCntWidth-1:0]      r_cnt;
   logic [LineBits-1:0]          r_lineBuf;
   logic [LineBits-1:0]          r_rdata;
   logic [1:0]                   r_ack;
   logic                         r_cmd;
   logic                         r_cmdEn;
   logic [AddressBitWidth-1:0]   r_ramAddr;
   logic [DataBitWidth-1:0]      r_wrData;

   state_t                       w_state;
   logic                         w_grant;
   logic [LineBits-1:0]          w_wdata;
   logic [WordCntWidth-1:0]      w_cnt;
   logic [LineBits-1:0]          w_lineBuf;
   logic [LineBits-1:0]          w_rdata;
   logic [1:0]                   w_ack;
   logic                         w_cmd;
   logic                         w_cmdEn;
   logic [AddressBitWidth-1:0]   w_ramAddr;
   logic [DataBitWidth-1:0]      w_wrData;
   logic                         w_update;
   logic                         w_arbGrant;
   logic                         w_arbValid;

   rr_arbiter u_arbiter (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_req    (req),
      .i_update (w_update),
      .o_grant  (w_arbGrant),
      .o_valid  (w_arbValid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= WaitCalib;
         r_grant   <= 1'b0;
         r_wdata   <= '0;
         r_cnt     <= '0;
         r_lineBuf <= '0;
         r_rdata   <= '0;
         r_ack     <= '0;
         r_cmd     <= CMD_READ;
         r_cmdEn   <= 1'b0;
         r_ramAddr <= '0;
         r_wrData  <= '0;
      end else begin
         r_state   <= w_state;
         r_grant   <= w_grant;
         r_wdata   <= w_wdata;
         r_cnt     <= w_cnt;
         r_lineBuf <= w_lineBuf;
         r_rdata   <= w_rdata;
         r_ack     <= w_ack;
         r_cmd     <= w_cmd;
         r_cmdEn   <= w_cmdEn;
         r_ramAddr <= w_ramAddr;
         r_wrData  <= w_wrData;
      end
   end

   // No grant while an ack is still out: the finished requester has not yet had a cycle to drop req.
   always_comb begin
      w_state   = r_state;
      w_grant   = r_grant;
      w_wdata   = r_wdata;
      w_cnt     = r_cnt;
      w_lineBuf = r_lineBuf;
      w_rdata   = r_rdata;
      w_ack     = '0;
      w_cmd     = r_cmd;
      w_cmdEn   = 1'b0;
      w_ramAddr = r_ramAddr;
      w_wrData  = r_wrData;
      w_update  = 1'b0;

      unique case (r_state)
         WaitCalib: begin
            if (ram_init_calib) begin
               w_state = Idle;
            end
         end

         Idle: begin
            if (!ram_busy && w_arbValid && (r_ack == 2'b00)) begin
               w_update  = 1'b1;
               w_grant   = w_arbGrant;
               w_wdata   = req_wdata[w_arbGrant];
               w_cmdEn   = 1'b1;
               w_cmd     = req_we[w_arbGrant] ? CMD_WRITE : CMD_READ;
               w_ramAddr = {req_addr[w_arbGrant], {WordCntWidth{1'b0}}};
               w_cnt     = '0;
               if (req_we[w_arbGrant]) begin
                  w_wrData = req_wdata[w_arbGrant][DataBitWidth-1:0];
                  w_cnt    = WordCntWidth'(1);
                  w_state  = WriteBurst;
               end else begin
                  w_state  = ReadWait;
               end
            end
         end

         // The counter wrapping back to 0 marks that the last word has already been driven.
         WriteBurst: begin
            if (r_cnt == '0) begin
               w_ack[r_grant] = 1'b1;
               w_state        = Idle;
            end else begin
               w_wrData = r_wdata[r_cnt*DataBitWidth +: DataBitWidth];
               w_cnt    = r_cnt + 1'b1;
            end
         end

         ReadWait: begin
            if (ram_rd_data_valid) begin
               w_lineBuf[r_cnt*DataBitWidth +: DataBitWidth] = ram_rd_data;
               w_cnt   = r_cnt + 1'b1;
               w_state = ReadBurst;
            end
         end

         ReadBurst: begin
            if (ram_rd_data_valid) begin
               w_lineBuf[r_cnt*DataBitWidth +: DataBitWidth] = ram_rd_data;
               w_cnt = r_cnt + 1'b1;
               if (r_cnt == LastWord) begin
                  w_rdata        = w_lineBuf;
                  w_ack[r_grant] = 1'b1;
                  w_state        = Idle;
               end
            end
         end

         default: begin
            w_state = WaitCalib;
         end
      endcase
   end

   assign ack           = r_ack;
   assign rdata         = r_rdata;
   assign ram_cmd       = r_cmd;
   assign ram_cmd_en    = r_cmdEn;
   assign ram_addr      = r_ramAddr;
   assign ram_wr_data   = r_wrData;
   assign ram_data_mask = '0;

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Directed bench for burst_ram_arbiter with a small burst RAM emulator and per-scenario checks.
module tb_burst_ram_arbiter;

   localparam logic [255:0] LINE0 = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
   localparam logic [255:0] LINE1 = {64'hB4, 64'hB3, 64'hB2, 64'hB1};
   localparam logic [255:0] LINE2 = {64'hC4, 64'hC3, 64'hC2, 64'hC1};
   localparam logic [255:0] LINE3 = {64'h44, 64'h33, 64'h22, 64'h11};

   logic         clk = 1'b0;
   logic         rst_n;
   logic [1:0]   req;
   logic [1:0]   req_we;
   logic [1:0]   req_addr [2];
   logic [255:0] req_wdata [2];
   logic [1:0]   ack;
   logic [255:0] rdata;
   logic         ram_cmd;
   logic         ram_cmd_en;
   logic [3:0]   ram_addr;
   logic [63:0]  ram_wr_data;
   logic [7:0]   ram_data_mask;
   logic [63:0]  ram_rd_data;
   logic         ram_rd_data_valid;
   logic         ram_init_calib;
   logic         ram_busy;

   int checks = 0;
   int passes = 0;

   // RAM emulator and monitor state; written only by the emulator process
   logic [63:0]  mem [16];
   int           cycle = 0;
   int           cmdCount = 0;
   int           lastCmdCycle = 0;
   logic [3:0]   lastCmdAddr = '0;
   logic         lastCmdType = 1'b0;
   int           wrCycle [4];
   logic [15:0]  writtenMap = '0;
   int           ackCount [2];
   int           ackCycle [2];
   int           ackOrder [$];
   logic [255:0] rdataAtAck = '0;
   int           cmdEnRun = 0;
   int           cmdEnLongest = 0;
   int           rdPending = 0;
   int           rdWait = 0;
   int           rdIdx = 0;
   int           gapLeft = 0;
   logic [3:0]   rdAddr = '0;
   int           wrRemaining = 0;
   int           wrIdx = 0;
   logic [3:0]   wrAddr = '0;

   // Scenario knobs for the emulator, set by the test tasks
   int readDelay  = 2;
   bit gapEnable  = 1'b0;
   bit strayValid = 1'b0;

   burst_ram_arbiter dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .req               (req),
      .req_we            (req_we),
      .req_addr          (req_addr),
      .req_wdata         (req_wdata),
      .ack               (ack),
      .rdata             (rdata),
      .ram_cmd           (ram_cmd),
      .ram_cmd_en        (ram_cmd_en),
      .ram_addr          (ram_addr),
      .ram_wr_data       (ram_wr_data),
      .ram_data_mask     (ram_data_mask),
      .ram_rd_data       (ram_rd_data),
      .ram_rd_data_valid (ram_rd_data_valid),
      .ram_init_calib    (ram_init_calib),
      .ram_busy          (ram_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   // Burst RAM emulator: samples commands and write words on the falling edge and drives read words then
   initial begin
      logic [3:0] idx;
      for (int i = 0; i < 16; i++) mem[i] = 64'hA0 + 64'(i);
      ackCount[0] = 0;
      ackCount[1] = 0;
      ackCycle[0] = 0;
      ackCycle[1] = 0;
      for (int k = 0; k < 4; k++) wrCycle[k] = 0;
      ram_rd_data       = '0;
      ram_rd_data_valid = 1'b0;
      forever begin
         @(negedge clk);
         ram_rd_data_valid = 1'b0;
         if (!rst_n) begin
            rdPending   = 0;
            wrRemaining = 0;
            cmdEnRun    = 0;
         end else begin
            if (ack[0]) begin ackCount[0]++; ackCycle[0] = cycle; ackOrder.push_back(0); end
            if (ack[1]) begin ackCount[1]++; ackCycle[1] = cycle; ackOrder.push_back(1); end
            if (ack != 2'b00) rdataAtAck = rdata;
            if (ram_cmd_en) begin
               cmdEnRun++;
               if (cmdEnRun > cmdEnLongest) cmdEnLongest = cmdEnRun;
            end else begin
               cmdEnRun = 0;
            end
            if (wrRemaining > 0) begin
               idx = 4'(wrAddr + 4'(wrIdx));
               mem[idx] = ram_wr_data;
               writtenMap[idx] = 1'b1;
               wrCycle[wrIdx] = cycle;
               wrIdx++;
               wrRemaining--;
            end
            if (rdPending > 0) begin
               if (rdWait > 0) begin
                  rdWait--;
               end else if (gapEnable && rdIdx == 2 && gapLeft > 0) begin
                  gapLeft--;
               end else begin
                  ram_rd_data_valid = 1'b1;
                  ram_rd_data = mem[4'(rdAddr + 4'(rdIdx))];
                  rdIdx++;
                  rdPending--;
               end
            end else if (strayValid) begin
               ram_rd_data_valid = 1'b1;
               ram_rd_data = 64'hDEAD_BEEF_0BAD_F00D;
            end
            if (ram_cmd_en) begin
               cmdCount++;
               lastCmdCycle = cycle;
               lastCmdAddr  = ram_addr;
               lastCmdType  = ram_cmd;
               if (ram_cmd) begin
                  mem[ram_addr] = ram_wr_data;
                  writtenMap[ram_addr] = 1'b1;
                  wrCycle[0]  = cycle;
                  wrAddr      = ram_addr;
                  wrIdx       = 1;
                  wrRemaining = 3;
               end else begin
                  rdAddr    = ram_addr;
                  rdIdx     = 0;
                  rdWait    = readDelay;
                  gapLeft   = 2;
                  rdPending = 4;
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   // Holds one requester's line request until its ack is observed on a falling edge
   task automatic applyRequest(input int idx, input logic we, input logic [1:0] line,
                               input logic [255:0] wdata, output bit timedOut);
      int n;
      req_we[idx]    = we;
      req_addr[idx]  = line;
      req_wdata[idx] = wdata;
      req[idx]       = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ack[idx] && n < 300);
      timedOut = !ack[idx];
      req[idx] = 1'b0;
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      req = '0;
      req_we = '0;
      req_addr[0] = '0;
      req_addr[1] = '0;
      req_wdata[0] = '0;
      req_wdata[1] = '0;
      ram_init_calib = 1'b0;
      ram_busy = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (ack !== 2'b00) $display("[TB] FAIL reset_ack: got %b expected 00", ack); else passes++;
      checks++; if (rdata !== '0) $display("[TB] FAIL reset_rdata: got %h expected 0", rdata); else passes++;
      checks++; if (ram_cmd_en !== 1'b0) $display("[TB] FAIL reset_cmd_en: got %b expected 0", ram_cmd_en); else passes++;
      checks++; if (ram_cmd !== 1'b0) $display("[TB] FAIL reset_cmd: got %b expected 0", ram_cmd); else passes++;
      checks++; if (ram_addr !== 4'd0) $display("[TB] FAIL reset_addr: got %0d expected 0", ram_addr); else passes++;
      checks++; if (ram_wr_data !== 64'd0) $display("[TB] FAIL reset_wr_data: got %h expected 0", ram_wr_data); else passes++;
      checks++; if (ram_data_mask !== 8'd0) $display("[TB] FAIL data_mask: got %h expected 0", ram_data_mask); else passes++;
      rst_n = 1'b1;
   endtask

   task automatic test_calibration;
      int c0 = cmdCount;
      int a0 = ackCount[0];
      int n = 0;
      readDelay = 2;
      req_we[0] = 1'b0;
      req_addr[0] = 2'd0;
      req[0] = 1'b1;
      repeat (10) @(negedge clk);
      #1;
      checks++; if (cmdCount !== c0) $display("[TB] FAIL calib_no_cmd: got %0d commands expected 0", cmdCount - c0); else passes++;
      ram_init_calib = 1'b1;
      do begin @(negedge clk); #1; n++; end while (ackCount[0] == a0 && n < 200);
      req[0] = 1'b0;
      checks++; if (ackCount[0] !== a0 + 1) $display("[TB] FAIL calib_ack: got %0d acks expected 1", ackCount[0] - a0); else passes++;
      checks++; if (cmdCount !== c0 + 1) $display("[TB] FAIL calib_cmd_count: got %0d expected 1", cmdCount - c0); else passes++;
      checks++; if (lastCmdType !== 1'b0 || lastCmdAddr !== 4'd0) $display("[TB] FAIL calib_cmd: got type %b addr %0d expected type 0 addr 0", lastCmdType, lastCmdAddr); else passes++;
      checks++; if (rdata !== LINE0) $display("[TB] FAIL calib_rdata: got %h expected %h", rdata, LINE0); else passes++;
   endtask

   task automatic test_single_write;
      bit to;
      bit ok = 1'b1;
      int a1 = ackCount[1];
      logic [255:0] line3Mem;
      logic [255:0] line0Mem;
      applyRequest(1, 1'b1, 2'd3, LINE3, to);
      checks++; if (to) $display("[TB] FAIL write_timeout: got no ack[1] expected ack within 300 cycles"); else passes++;
      checks++; if (lastCmdType !== 1'b1 || lastCmdAddr !== 4'd12) $display("[TB] FAIL write_cmd: got type %b addr %0d expected type 1 addr 12", lastCmdType, lastCmdAddr); else passes++;
      for (int k = 0; k < 4; k++) if (wrCycle[k] != lastCmdCycle + k) ok = 1'b0;
      checks++; if (!ok) $display("[TB] FAIL write_word_timing: got cycles %0d %0d %0d %0d expected %0d..%0d", wrCycle[0], wrCycle[1], wrCycle[2], wrCycle[3], lastCmdCycle, lastCmdCycle + 3); else passes++;
      checks++; if (ackCycle[1] !== lastCmdCycle + 4) $display("[TB] FAIL write_ack_timing: got cycle %0d expected %0d", ackCycle[1], lastCmdCycle + 4); else passes++;
      checks++; if (ackCount[1] !== a1 + 1) $display("[TB] FAIL write_ack_count: got %0d expected 1", ackCount[1] - a1); else passes++;
      line3Mem = {mem[15], mem[14], mem[13], mem[12]};
      line0Mem = {mem[3], mem[2], mem[1], mem[0]};
      checks++; if (line3Mem !== LINE3) $display("[TB] FAIL write_mem_line3: got %h expected %h", line3Mem, LINE3); else passes++;
      checks++; if (line0Mem !== LINE0) $display("[TB] FAIL write_line0_intact: got %h expected %h", line0Mem, LINE0); else passes++;
      checks++; if (writtenMap !== 16'hF000) $display("[TB] FAIL write_addr_range: got map %h expected f000", writtenMap); else passes++;
      checks++; if (cmdEnLongest !== 1) $display("[TB] FAIL cmd_en_width: got %0d cycles expected 1", cmdEnLongest); else passes++;
      checks++; if (rdata !== LINE0) $display("[TB] FAIL write_keeps_rdata: got %h expected %h", rdata, LINE0); else passes++;
   endtask

   task automatic test_single_read;
      bit to;
      int a0 = ackCount[0];
      int a1 = ackCount[1];
      readDelay = 6;
      applyRequest(0, 1'b0, 2'd3, '0, to);
      checks++; if (to) $display("[TB] FAIL read_timeout: got no ack[0] expected ack within 300 cycles"); else passes++;
      checks++; if (rdata !== LINE3) $display("[TB] FAIL read_rdata: got %h expected %h", rdata, LINE3); else passes++;
      checks++; if (rdataAtAck !== LINE3) $display("[TB] FAIL read_rdata_at_ack: got %h expected %h", rdataAtAck, LINE3); else passes++;
      checks++; if (lastCmdType !== 1'b0 || lastCmdAddr !== 4'd12) $display("[TB] FAIL read_cmd: got type %b addr %0d expected type 0 addr 12", lastCmdType, lastCmdAddr); else passes++;
      repeat (5) @(negedge clk);
      #1;
      checks++; if (ackCount[0] !== a0 + 1 || ackCount[1] !== a1) $display("[TB] FAIL read_ack_once: got ack0 %0d ack1 %0d expected 1 and 0", ackCount[0] - a0, ackCount[1] - a1); else passes++;
   endtask

   task automatic test_rdata_hold_and_gap;
      bit to;
      readDelay = 0;
      applyRequest(1, 1'b1, 2'd1, LINE1, to);
      checks++; if (rdata !== LINE3) $display("[TB] FAIL hold_after_write: got %h expected %h", rdata, LINE3); else passes++;
      gapEnable = 1'b1;
      applyRequest(0, 1'b0, 2'd1, '0, to);
      gapEnable = 1'b0;
      checks++; if (to) $display("[TB] FAIL gap_timeout: got no ack[0] expected ack within 300 cycles"); else passes++;
      checks++; if (rdata !== LINE1) $display("[TB] FAIL gap_rdata: got %h expected %h", rdata, LINE1); else passes++;
   endtask

   task automatic test_stray_valid;
      bit to;
      logic [255:0] line2Mem;
      readDelay = 1;
      strayValid = 1'b1;
      repeat (4) @(negedge clk);
      applyRequest(1, 1'b1, 2'd2, LINE2, to);
      strayValid = 1'b0;
      line2Mem = {mem[11], mem[10], mem[9], mem[8]};
      checks++; if (line2Mem !== LINE2) $display("[TB] FAIL stray_write_mem: got %h expected %h", line2Mem, LINE2); else passes++;
      checks++; if (rdata !== LINE1) $display("[TB] FAIL stray_rdata_hold: got %h expected %h", rdata, LINE1); else passes++;
      applyRequest(0, 1'b0, 2'd2, '0, to);
      checks++; if (rdata !== LINE2) $display("[TB] FAIL stray_read_rdata: got %h expected %h", rdata, LINE2); else passes++;
   endtask

   task automatic test_contention;
      int o;
      int n = 0;
      bit ok = 1'b1;
      rst_n = 1'b0;
      readDelay = 1;
      repeat (2) @(negedge clk);
      #1;
      o = ackOrder.size();
      req_we = 2'b00;
      req_addr[0] = 2'd1;
      req_addr[1] = 2'd3;
      req = 2'b11;
      rst_n = 1'b1;
      do begin @(negedge clk); #1; n++; end while (ackOrder.size() < o + 4 && n < 400);
      req = 2'b00;
      checks++; if (ackOrder.size() < o + 4) $display("[TB] FAIL contention_timeout: got %0d acks expected 4", ackOrder.size() - o); else passes++;
      if (ackOrder.size() >= o + 4) begin
         for (int k = 0; k < 4; k++) if (ackOrder[o + k] != (k % 2)) ok = 1'b0;
      end else begin
         ok = 1'b0;
      end
      checks++; if (!ok) $display("[TB] FAIL contention_order: got a different grant order expected 0,1,0,1"); else passes++;
      checks++; if (rdataAtAck !== LINE3) $display("[TB] FAIL contention_last_rdata: got %h expected %h", rdataAtAck, LINE3); else passes++;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_busy;
      bit to;
      int c0 = cmdCount;
      ram_busy = 1'b1;
      req_we[1] = 1'b0;
      req_addr[1] = 2'd3;
      req[1] = 1'b1;
      repeat (8) @(negedge clk);
      #1;
      checks++; if (cmdCount !== c0) $display("[TB] FAIL busy_no_cmd: got %0d commands expected 0", cmdCount - c0); else passes++;
      ram_busy = 1'b0;
      applyRequest(1, 1'b0, 2'd3, '0, to);
      checks++; if (to || cmdCount !== c0 + 1) $display("[TB] FAIL busy_release: got %0d commands timeout %b expected 1 command", cmdCount - c0, to); else passes++;
      checks++; if (rdata !== LINE3) $display("[TB] FAIL busy_rdata: got %h expected %h", rdata, LINE3); else passes++;
   endtask

   task automatic test_reset_mid_read;
      bit to;
      int a0;
      int n = 0;
      readDelay = 0;
      applyRequest(0, 1'b1, 2'd0, LINE2, to);
      a0 = ackCount[0];
      req_we[0] = 1'b0;
      req_addr[0] = 2'd3;
      req[0] = 1'b1;
      do begin @(negedge clk); #1; n++; end while (rdIdx != 2 && n < 200);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      req = 2'b00;
      #1;
      checks++; if (ack !== 2'b00 || ram_cmd_en !== 1'b0) $display("[TB] FAIL midreset_ctrl: got ack %b cmd_en %b expected 00 and 0", ack, ram_cmd_en); else passes++;
      checks++; if (rdata !== '0) $display("[TB] FAIL midreset_rdata: got %h expected 0", rdata); else passes++;
      checks++; if (ram_addr !== 4'd0 || ram_wr_data !== 64'd0 || ram_cmd !== 1'b0) $display("[TB] FAIL midreset_ram_outputs: got addr %0d wr %h cmd %b expected 0", ram_addr, ram_wr_data, ram_cmd); else passes++;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      #1;
      checks++; if (ackCount[0] !== a0) $display("[TB] FAIL midreset_no_ack: got %0d acks expected 0", ackCount[0] - a0); else passes++;
      applyRequest(0, 1'b0, 2'd3, '0, to);
      checks++; if (to || rdata !== LINE3) $display("[TB] FAIL midreset_recover: got %h timeout %b expected %h", rdata, to, LINE3); else passes++;
   endtask

   task automatic test_drop_req;
      int c0 = cmdCount;
      int a1 = ackCount[1];
      int n = 0;
      readDelay = 3;
      req_we[1] = 1'b0;
      req_addr[1] = 2'd1;
      req[1] = 1'b1;
      do begin @(negedge clk); #1; n++; end while (cmdCount == c0 && n < 200);
      req[1] = 1'b0;
      n = 0;
      do begin @(negedge clk); #1; n++; end while (ackCount[1] == a1 && n < 200);
      checks++; if (ackCount[1] !== a1 + 1) $display("[TB] FAIL drop_req_ack: got %0d acks expected 1", ackCount[1] - a1); else passes++;
      checks++; if (rdata !== LINE1) $display("[TB] FAIL drop_req_rdata: got %h expected %h", rdata, LINE1); else passes++;
   endtask

   initial begin
      test_reset;
      test_calibration;
      test_single_write;
      test_single_read;
      test_rdata_hold_and_gap;
      test_stray_valid;
      test_contention;
      test_busy;
      test_reset_mid_read;
      test_drop_req;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
